// File: rtl/rr_dispatch8_pkg.sv
// Shared constants, state encoding and the round-robin search helper for rr_dispatch8.
package rr_dispatch8_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // Result of a rotation search: none=1 when no channel is enabled.
  typedef struct packed {
    logic             none;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First enabled channel at or after 'start', wrapping mod NUM_CH.
  // Scanning offsets from the far end down lets the nearest hit win.
  function automatic pick_t pick(input logic [NUM_CH-1:0] mask,
                                 input logic [SEL_W-1:0]  start);
    pick_t            r;
    logic [SEL_W-1:0] k;
    r.none = (mask == '0);
    r.idx  = start;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      k = start + SEL_W'(i);
      if (mask[k]) r.idx = k;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_dispatch8_dmux8way.sv
// 1-to-8 demultiplexer gate: routes 'in' to the output bit selected by 'sel'.
module DMux8Way
  import rr_dispatch8_pkg::*;
(
  input  logic              in,
  input  logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] out
);

  // One decode term per channel; at most one bit can be set.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_dec
    assign out[k] = in & (sel == SEL_W'(k));
  end

endmodule

// File: rtl/rr_dispatch8.sv
// Round-robin dispatcher: one-word holding register whose valid is steered
// to a single output channel; channels can be dropped via enable_mask.
module rr_dispatch8
  import rr_dispatch8_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] enable_mask,
  output logic [WIDTH-1:0]  out_data,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [SEL_W-1:0]  sel,
  output logic [15:0]       xfer_count
);

  state_t           st;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] sel_nxt;
  logic             full;
  logic             drain;
  logic             accept;
  pick_t            pk;

  assign full    = (st == FULL);
  assign drain   = full & out_ready[sel];
  assign sel_nxt = sel + SEL_W'(1);

  // When the held word leaves this cycle the search resumes just past it,
  // which is what ptr would hold next cycle; this keeps 1 word/cycle.
  assign pk       = pick(enable_mask, drain ? sel_nxt : ptr);
  assign in_ready = ~pk.none & (~full | drain);
  assign accept   = in_valid & in_ready;

  DMux8Way u_dmux (
    .in  (full),
    .sel (sel),
    .out (out_valid)
  );

  // Holding register, rotation pointer and transfer counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= EMPTY;
      ptr        <= '0;
      sel        <= '0;
      out_data   <= '0;
      xfer_count <= '0;
    end else begin
      if (drain) begin
        ptr        <= sel_nxt;
        xfer_count <= xfer_count + 16'd1;
      end
      // sel only moves on accept, so a held word never gets re-steered.
      if (accept) begin
        out_data <= in_data;
        sel      <= pk.idx;
        st       <= FULL;
      end else if (drain) begin
        st <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_rr_dispatch8.sv
// Self-checking bench for rr_dispatch8: scenario tasks plus a drain monitor
// that pops expected {sel,data} from a scoreboard queue.
module tb_rr_dispatch8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  enable_mask;
  logic [15:0] out_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [2:0]  sel;
  logic [15:0] xfer_count;

  typedef struct packed {
    logic [2:0]  sel;
    logic [15:0] data;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   stalls = 0;

  rr_dispatch8 #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .enable_mask (enable_mask),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sel         (sel),
    .xfer_count  (xfer_count)
  );

  always #5 clk = ~clk;

  // Drain monitor: inputs are driven just after posedge, so at negedge the
  // upcoming edge's transfer is already determined.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (out_valid & out_ready) != 8'h00) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL drain_unexpected: sel=%0d data=%h, no word expected", sel, out_data);
      end else begin
        e = sbq.pop_front();
        if (out_data !== e.data || sel !== e.sel || out_valid !== (8'h01 << e.sel)) begin
          fails++;
          $display("FAIL drain: got sel=%0d data=%h valid=%h, want sel=%0d data=%h valid=%h",
                   sel, out_data, out_valid, e.sel, e.data, 8'h01 << e.sel);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string nm, input logic [15:0] want);
    tests++;
    if (xfer_count !== want) begin
      fails++;
      $display("FAIL %s: xfer_count=%0d want %0d", nm, xfer_count, want);
    end
  endtask

  // Offer one word; called just after a posedge, returns just after the
  // accepting posedge. The expected channel is pushed once acceptance is seen.
  task automatic send(input logic [15:0] d, input logic [2:0] exp_sel);
    int t;
    t = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    if (!in_ready) stalls++;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready=%b want 1 for data %h", in_ready, d);
      in_valid = 1'b0;
    end else begin
      sbq.push_back('{sel: exp_sel, data: d});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    sbq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    enable_mask = 8'hFF;
    out_ready   = 8'hFF;
    reset       = 1'b1;
    in_valid    = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (out_valid !== 8'h00 || sel !== 3'd0 || out_data !== 16'h0 || xfer_count !== 16'h0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: valid=%h sel=%0d data=%h cnt=%0d rdy=%b want 00/0/0000/0/1",
               out_valid, sel, out_data, xfer_count, in_ready);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    send(16'h1234, 3'd0);
    tests++;
    if (out_valid !== 8'h01 || out_data !== 16'h1234) begin
      fails++;
      $display("FAIL latency: valid=%h data=%h want 01/1234", out_valid, out_data);
    end
    idle(2);
    check_cnt("reset_cnt", 16'd1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    stalls = 0;
    for (int i = 0; i < 10; i++) send(16'h0100 + 16'(i), 3'(i % 8));
    idle(2);
    tests++;
    if (stalls !== 0) begin
      fails++;
      $display("FAIL b2b_in_ready: stalls=%0d want 0", stalls);
    end
    check_cnt("b2b_cnt", 16'd10);
  endtask

  task automatic test_sparse_mask();
    do_reset();
    enable_mask = 8'h24;
    send(16'h2001, 3'd2);
    send(16'h2002, 3'd5);
    send(16'h2003, 3'd2);
    send(16'h2004, 3'd5);
    idle(2);
    check_cnt("sparse_cnt", 16'd4);
    enable_mask = 8'hFF;
  endtask

  task automatic test_backpressure();
    do_reset();
    send(16'h3000, 3'd0);
    send(16'h3001, 3'd1);
    send(16'h3002, 3'd2);
    send(16'hBEEF, 3'd3);
    out_ready = 8'hF7;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 8'h08 || out_data !== 16'hBEEF || in_ready !== 1'b0 || sel !== 3'd3) begin
        fails++;
        $display("FAIL bp_hold[%0d]: valid=%h data=%h rdy=%b sel=%0d want 08/beef/0/3",
                 c, out_valid, out_data, in_ready, sel);
      end
    end
    check_cnt("bp_hold_cnt", 16'd3);
    @(posedge clk);
    #1;
    out_ready = 8'hFF;
    idle(2);
    check_cnt("bp_release_cnt", 16'd4);
  endtask

  task automatic test_mask_change();
    do_reset();
    send(16'h4000, 3'd0);
    send(16'hA001, 3'd1);
    out_ready   = 8'hFD;
    enable_mask = 8'h80;
    idle(2);
    tests++;
    if (out_valid !== 8'h02 || sel !== 3'd1) begin
      fails++;
      $display("FAIL mask_hold: valid=%h sel=%0d want 02/1", out_valid, sel);
    end
    out_ready = 8'hFF;
    send(16'hA007, 3'd7);
    idle(2);
    check_cnt("mask_cnt", 16'd3);
    enable_mask = 8'h00;
    in_data     = 16'hDEAD;
    in_valid    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("FAIL mask_zero_ready[%0d]: in_ready=%b want 0", c, in_ready);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    idle(2);
    tests++;
    if (out_valid !== 8'h00 || xfer_count !== 16'd3) begin
      fails++;
      $display("FAIL mask_zero_idle: valid=%h cnt=%0d want 00/3", out_valid, xfer_count);
    end
    enable_mask = 8'hFF;
  endtask

  task automatic test_async_reset();
    do_reset();
    send(16'h5000, 3'd0);
    send(16'hC0DE, 3'd1);
    out_ready = 8'h00;
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (out_valid !== 8'h00 || sel !== 3'd0 || xfer_count !== 16'd0) begin
      fails++;
      $display("FAIL async_reset: valid=%h sel=%0d cnt=%0d want 00/0/0", out_valid, sel, xfer_count);
    end
    sbq.delete();
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 8'hFF;
    @(posedge clk);
    #1;
    send(16'hD00D, 3'd0);
    idle(2);
    check_cnt("async_after_cnt", 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    in_data     = 16'h0;
    in_valid    = 1'b0;
    enable_mask = 8'hFF;
    out_ready   = 8'hFF;
    test_reset();
    test_back_to_back();
    test_sparse_mask();
    test_backpressure();
    test_mask_change();
    test_async_reset();
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_left: %0d words undrained, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
